// File: rtl/arbitro_contador_pkg.sv
// ============================================================================
// Module  : arbitro_contador_pkg
// Purpose : shared state encoding and default widths for arbitro_contador
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package arbitro_contador_pkg;

    typedef enum logic [1:0] {
        S_ESPERA    = 2'd0,
        S_EMITIR    = 2'd1,
        S_AGUARDAR  = 2'd2,
        S_RESPONDER = 2'd3
    } estado_t;

    // Indices 0..3 address individual queues, IDX_TOTAL is the aggregate count
    localparam int IDX_TOTAL   = 4;
    localparam int NUM_IDX_DEF = IDX_TOTAL + 1;
    localparam int IDX_W_DEF   = 3;
    localparam int CNT_W_DEF   = 5;

endpackage

`default_nettype wire

// File: rtl/arbitro_contador_rr_selector.sv
// ============================================================================
// Module  : arbitro_contador_rr_selector
// Purpose : combinational requester picker; round-robin from ptr+1 with wrap,
//           or lowest-index fixed priority when ARBITRO_PRIO_FIJA_EN is defined
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module arbitro_contador_rr_selector #(
    parameter int N_REQ = 2,
    parameter int PTR_W = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt_oh,
    output logic [PTR_W-1:0] gnt_idx
);

`ifdef ARBITRO_PRIO_FIJA_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    always_comb begin
        logic found;
        found   = 1'b0;
        gnt_oh  = '0;
        gnt_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req[i]) begin
                found      = 1'b1;
                gnt_oh[i]  = 1'b1;
                gnt_idx    = PTR_W'(i);
            end
        end
    end
`else
    always_comb begin
        logic found;
        int   j;
        found   = 1'b0;
        j       = 0;
        gnt_oh  = '0;
        gnt_idx = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            j = (int'(ptr) + i) % N_REQ;
            if (!found && req[j]) begin
                found      = 1'b1;
                gnt_oh[j]  = 1'b1;
                gnt_idx    = PTR_W'(j);
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/arbitro_contador.sv
// ============================================================================
// Module  : arbitro_contador
// Purpose : shares the per-queue word counter between N_REQ requesters;
//           ARBITRO_PRIO_FIJA_EN selects fixed priority instead of round-robin
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module arbitro_contador
    import arbitro_contador_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int IDX_W   = IDX_W_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int NUM_IDX = NUM_IDX_DEF,
    parameter int TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   idle,
    input  logic [N_REQ-1:0]       sol_req,
    input  logic [N_REQ*IDX_W-1:0] sol_idx,
    output logic [N_REQ-1:0]       sol_ack,
    output logic [CNT_W-1:0]       sol_dato,
    output logic                   sol_err,
    output logic [IDX_W-1:0]       cnt_idx,
    output logic                   cnt_req,
    input  logic                   cnt_valid,
    input  logic [CNT_W-1:0]       cnt_dato,
    output logic                   ocupado
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    estado_t            state_q, state_d;
    logic [PTR_W-1:0]   gnt_q, gnt_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   dato_q, dato_d;
    logic               err_q, err_d;
    logic [N_REQ-1:0]   sol_ack_q, sol_ack_d;
    logic [CNT_W-1:0]   sol_dato_q, sol_dato_d;
    logic               sol_err_q, sol_err_d;
    logic [IDX_W-1:0]   cnt_idx_q, cnt_idx_d;
    logic               cnt_req_q, cnt_req_d;
    logic               ocupado_q, ocupado_d;

    logic [N_REQ-1:0]   w_gnt_oh;
    logic [PTR_W-1:0]   w_gnt_idx;
    logic [IDX_W-1:0]   w_sel_idx;

    arbitro_contador_rr_selector #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_selector (
        .req     (sol_req),
        .ptr     (ptr_q),
        .gnt_oh  (w_gnt_oh),
        .gnt_idx (w_gnt_idx)
    );

    assign w_sel_idx = sol_idx[w_gnt_idx*IDX_W +: IDX_W];

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        ptr_d      = ptr_q;
        timer_d    = timer_q;
        dato_d     = dato_q;
        err_d      = err_q;
        sol_ack_d  = '0;
        sol_dato_d = '0;
        sol_err_d  = 1'b0;
        cnt_idx_d  = cnt_idx_q;
        cnt_req_d  = cnt_req_q;

        case (state_q)
            S_ESPERA: begin
                if (idle && (|w_gnt_oh)) begin
                    gnt_d   = w_gnt_idx;
                    timer_d = '0;
                    dato_d  = '0;
                    if (int'(w_sel_idx) >= NUM_IDX) begin
                        err_d   = 1'b1;
                        state_d = S_RESPONDER;
                    end else begin
                        err_d     = 1'b0;
                        cnt_idx_d = w_sel_idx;
                        cnt_req_d = 1'b1;
                        state_d   = S_EMITIR;
                    end
                end
            end
            S_EMITIR: begin
                timer_d = timer_q + TMR_W'(1);
                // Leaving IDLE here must also drop cnt_req before the counter acts on it
                if (!idle) begin
                    err_d     = 1'b1;
                    dato_d    = '0;
                    cnt_req_d = 1'b0;
                    state_d   = S_RESPONDER;
                end else begin
                    state_d = S_AGUARDAR;
                end
            end
            S_AGUARDAR: begin
                timer_d = timer_q + TMR_W'(1);
                if (!idle) begin
                    err_d     = 1'b1;
                    dato_d    = '0;
                    cnt_req_d = 1'b0;
                    state_d   = S_RESPONDER;
                end else if (cnt_valid) begin
                    err_d     = 1'b0;
                    dato_d    = cnt_dato;
                    cnt_req_d = 1'b0;
                    state_d   = S_RESPONDER;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    err_d     = 1'b1;
                    dato_d    = '0;
                    cnt_req_d = 1'b0;
                    state_d   = S_RESPONDER;
                end
            end
            S_RESPONDER: begin
                sol_ack_d[gnt_q] = 1'b1;
                sol_dato_d       = dato_q;
                sol_err_d        = err_q;
                cnt_req_d        = 1'b0;
                ptr_d            = gnt_q;
                state_d          = S_ESPERA;
            end
            default: begin
                cnt_req_d = 1'b0;
                state_d   = S_ESPERA;
            end
        endcase

        ocupado_d = (state_d != S_ESPERA);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_ESPERA;
            gnt_q      <= '0;
            ptr_q      <= PTR_W'(N_REQ - 1);
            timer_q    <= '0;
            dato_q     <= '0;
            err_q      <= 1'b0;
            sol_ack_q  <= '0;
            sol_dato_q <= '0;
            sol_err_q  <= 1'b0;
            cnt_idx_q  <= '0;
            cnt_req_q  <= 1'b0;
            ocupado_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            ptr_q      <= ptr_d;
            timer_q    <= timer_d;
            dato_q     <= dato_d;
            err_q      <= err_d;
            sol_ack_q  <= sol_ack_d;
            sol_dato_q <= sol_dato_d;
            sol_err_q  <= sol_err_d;
            cnt_idx_q  <= cnt_idx_d;
            cnt_req_q  <= cnt_req_d;
            ocupado_q  <= ocupado_d;
        end
    end

    assign sol_ack  = sol_ack_q;
    assign sol_dato = sol_dato_q;
    assign sol_err  = sol_err_q;
    assign cnt_idx  = cnt_idx_q;
    assign cnt_req  = cnt_req_q;
    assign ocupado  = ocupado_q;

endmodule

`default_nettype wire

// File: doc/arbitro_contador.md
Name: arbitro_contador

Overview:
- Shares the per-queue word counter (`contador`) between N_REQ requesters. Typical requesters are the flow-control logic and the debug/status readout.
- Accepts a request as an index, drives the counter's `idx`/`req` while the system is in IDLE, captures `contador_out` on `valid_contador`, and returns the value to the granted requester.
- Round-robin arbitration, timeout protection, and abort if the system leaves IDLE.

Parameters:
- N_REQ, 2, number of requesters
- IDX_W, 3, width of the counter index
- CNT_W, 5, width of the counter value
- NUM_IDX, 5, legal indices 0..NUM_IDX-1 (0-3 are per-queue, 4 is total)
- TIMEOUT, 15, max cycles to wait for cnt_valid after cnt_req rises

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- idle  in  1  system IDLE indication; counter reads are only legal while high
- sol_req  in  N_REQ  per-requester request, level, held until its sol_ack
- sol_idx  in  N_REQ*IDX_W  requested index, requester r in bits [r*IDX_W +: IDX_W]
- sol_ack  out  N_REQ  one-cycle completion pulse to the granted requester
- sol_dato  out  CNT_W  result, valid only in the sol_ack cycle
- sol_err  out  1  qualifies sol_ack: 1 = bad index, timeout or IDLE abort
- cnt_idx  out  IDX_W  to counter idx
- cnt_req  out  1  to counter req
- cnt_valid  in  1  from counter valid_contador
- cnt_dato  in  CNT_W  from counter contador_out
- ocupado  out  1  high in any state other than S_ESPERA

Behaviour:
- All outputs are registered. Reset (reset=0, async) forces:
  - state S_ESPERA
  - sol_ack=0, sol_dato=0, sol_err=0, cnt_req=0, cnt_idx=0, ocupado=0
  - timer=0, rr pointer=N_REQ-1, so requester 0 is served first after reset
- S_ESPERA: when idle=1 and any sol_req bit is set, pick requester g by round-robin, searching from pointer+1 with wrap. Latch g and sol_idx[g].
  - If latched idx >= NUM_IDX: go to S_RESPONDER with err=1, dato=0; the counter is never touched.
  - Otherwise go to S_EMITIR.
  - With idle=0, requests wait and are not granted.
- S_EMITIR: cnt_idx=latched idx, cnt_req=1, timer=0; next state S_AGUARDAR.
- S_AGUARDAR: cnt_req stays 1 and cnt_idx stays stable. timer increments each cycle. Exits, checked in this order:
  - idle=0: go to S_RESPONDER, err=1, dato=0 (abort).
  - cnt_valid=1: capture cnt_dato, err=0, go to S_RESPONDER. This wins over a timeout in the same cycle.
  - timer==TIMEOUT-1: go to S_RESPONDER, err=1, dato=0.
- S_RESPONDER:
  - sol_ack[g]=1 for exactly one cycle with sol_dato/sol_err.
  - cnt_req=0.
  - pointer<=g.
  - Next state S_ESPERA.
- cnt_req is never 1 while idle=0 at the prior clock edge. cnt_req deasserts on every path out of S_AGUARDAR.
- Latency: the cycle after the request is sampled, cnt_req=1. sol_ack follows the cycle after cnt_valid is sampled. With a 1-cycle counter, request-to-ack is 4 cycles.
- A requester must drop sol_req the cycle after its ack. A still-high sol_req is treated as a new request; with other requesters pending, it ranks last.
- sol_req or sol_idx changing after grant is ignored; the latched copy is used.
- Reset mid-transaction aborts immediately. No ack is issued.
- Only one transaction is outstanding at a time.

Optional Feature:
- Macro ARBITRO_PRIO_FIJA_EN.
- Defined: fixed priority, lowest-numbered pending requester always wins; the pointer is unused.
- Undefined (default): round-robin as above.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package holds:
  - state encodings S_ESPERA/S_EMITIR/S_AGUARDAR/S_RESPONDER (2-bit)
  - NUM_IDX, IDX_W, CNT_W defaults
  - idx constant IDX_TOTAL=4
- One sub-module, rr_selector:
  - combinational N_REQ-wide round-robin picker
  - inputs: request vector, pointer
  - outputs: one-hot grant and encoded index
  - fixed-priority variant selected by the macro

Test Plan:
- Reset and single read: reset low 3 cycles → all outputs 0. Then idle=1, sol_req[0]=1, idx=2; counter model returns valid with 7 one cycle after req → sol_ack[0] 4 cycles after the request, sol_dato=7, sol_err=0, cnt_idx=2.
- Contention: sol_req=2'b11 held continuously → grants alternate 0,1,0,1; with ARBITRO_PRIO_FIJA_EN, always 0.
- Bad index: idx=5 → sol_ack with sol_err=1, sol_dato=0 two cycles after the request; cnt_req never asserts.
- Timeout: counter never raises valid → sol_err=1 exactly TIMEOUT cycles after cnt_req rises (+1 for the ack register); cnt_req then drops.
- IDLE gating and abort:
  - idle=0 with a pending request → no cnt_req, ocupado=0.
  - idle dropping during S_AGUARDAR → next cycle ack with err=1.
- Async reset mid-S_AGUARDAR → outputs 0 immediately with no ack; the next request is served normally, requester 0 first.
